// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, flush, forwarding and mul/div sequencing control
//
// Purpose: stalls/flushes the PC, IF/ID and ID/EX registers, selects EX operand
// forwarding sources, tracks the multi-cycle multiply/divide unit and counts
// stall cycles. All state updates on the falling edge of clk, the same edge on
// which the pipeline registers capture.
//
// Ports:
//   clk, rst_n                   clock (falling-edge active), sync active-low reset
//   id_rs/id_rt/id_use_*         ID-stage source registers and their use flags
//   id_md_use, id_jump           ID uses HI/LO or mul/div unit; jump resolved in ID
//   ex_rd/ex_regwr/ex_memread    EX destination, write enable, load flag
//   ex_rs/ex_rt                  EX operand register numbers
//   ex_branch_taken              branch resolved taken in EX
//   ex_md_start/ex_md_is_div     start mul/div unit; 1 = divide
//   mem_rd/mem_regwr, wb_rd/wb_regwr  later-stage destinations for forwarding
//   pc_en, ifid_en               hold PC / IF/ID when 0
//   ifid_flush, idex_flush       load a bubble
//   fwd_a, fwd_b                 00 regfile, 01 EX/MEM result, 10 MEM/WB data
//   md_busy, md_done             unit busy; one-cycle result-ready pulse
//   stall_cnt                    stalled-cycle counter (wraps)
module hazard_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md_use,
  input  logic        id_jump,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwr,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_regwr,
  input  logic        wb_regwr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  mdState_t    state, stateNext;
  logic [7:0]  count, countNext;
  logic        mdDone, mdDoneNext;
  logic [31:0] stallCnt;

  logic loadUse, mdHazard, stall;

  // A load to r0 never creates a real dependency.
  assign loadUse = ex_memread & ex_regwr & (ex_rd != 5'd0) &
                   ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign mdHazard = md_busy & id_md_use;
  // A taken branch squashes the ID instruction, so its hazard is moot.
  assign stall    = (loadUse | mdHazard) & ~ex_branch_taken;

  // State register.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= 8'd0;
      mdDone   <= 1'b0;
      stallCnt <= 32'd0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      mdDone   <= mdDoneNext;
      stallCnt <= stallCnt + {31'd0, stall};
    end
  end

  // Next-state logic; a new start always wins, so a restarted op never reports done.
  always_comb begin
    stateNext  = state;
    countNext  = count;
    mdDoneNext = 1'b0;
    if (ex_md_start) begin
      stateNext = BUSY;
      countNext = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
    end else if (state == BUSY) begin
      if (count == 8'd0) begin
        stateNext  = IDLE;
        mdDoneNext = 1'b1;
      end else begin
        countNext = count - 8'd1;
      end
    end
  end

  // Output logic.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
      // EX/MEM holds the newer value, so it takes priority over MEM/WB.
      if (mem_regwr && mem_rd != 5'd0 && mem_rd == ex_rs)   fwd_a = 2'b01;
      else if (wb_regwr && wb_rd != 5'd0 && wb_rd == ex_rs) fwd_a = 2'b10;
      if (mem_regwr && mem_rd != 5'd0 && mem_rd == ex_rt)   fwd_b = 2'b01;
      else if (wb_regwr && wb_rd != 5'd0 && wb_rd == ex_rt) fwd_b = 2'b10;
    end
  end

  assign md_busy   = (state == BUSY);
  assign md_done   = mdDone;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
  logic        id_use_rs, id_use_rt, id_md_use, id_jump;
  logic        ex_regwr, ex_memread, ex_branch_taken, ex_md_start, ex_md_is_div;
  logic        mem_regwr, wb_regwr;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  int nAssert = 0;
  int nFail   = 0;
  logic [31:0] expStall = 0;

  hazard_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_use(id_md_use), .id_jump(id_jump),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memread(ex_memread),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the active (falling) edge; inputs are then changed and checked mid-cycle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_md_use = 0; id_jump = 0;
    ex_rd = 0; ex_regwr = 0; ex_memread = 0; ex_rs = 0; ex_rt = 0;
    ex_branch_taken = 0; ex_md_start = 0; ex_md_is_div = 0;
    mem_rd = 0; wb_rd = 0; mem_regwr = 0; wb_regwr = 0;
  endtask

  task automatic chkCtl(input string tag, input logic pc, input logic ifid,
                        input logic fIfid, input logic fIdex);
    chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, pc});
    chk({tag, ".ifid_en"}, {31'd0, ifid_en}, {31'd0, ifid});
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, fIfid});
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, fIdex});
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    // Forwarding candidate present during reset must be suppressed.
    mem_rd = 5; mem_regwr = 1; ex_rs = 5;
    tick(); tick();
    chkCtl("reset", 0, 0, 1, 1);
    chk("reset.fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset.md_done", {31'd0, md_done}, 32'd0);

    clr(); rst_n = 1'b1; tick();
    chkCtl("idle", 1, 1, 0, 0);

    // lw r2 in EX, ID reads rs=r2; a jump in ID is ignored while stalled.
    ex_memread = 1; ex_regwr = 1; ex_rd = 2; id_use_rs = 1; id_rs = 2; id_jump = 1; #1;
    chkCtl("lu_rs", 0, 0, 0, 1);
    tick(); expStall++;
    chk("lu_rs.stall_cnt", stall_cnt, expStall);
    // Bubble in EX, load now in MEM, dependent instruction in EX.
    clr(); mem_rd = 2; mem_regwr = 1; ex_rs = 2; #1;
    chkCtl("lu_after", 1, 1, 0, 0);
    chk("lu_after.fwd_a", {30'd0, fwd_a}, 32'd1);
    tick();
    chk("lu_after.stall_cnt", stall_cnt, expStall);

    // rt dependency stalls only when rt is actually read.
    clr(); ex_memread = 1; ex_regwr = 1; ex_rd = 7; id_rt = 7; id_use_rt = 0; #1;
    chkCtl("lu_rt_unused", 1, 1, 0, 0);
    id_use_rt = 1; #1;
    chkCtl("lu_rt", 0, 0, 0, 1);
    tick(); expStall++;
    chk("lu_rt.stall_cnt", stall_cnt, expStall);

    // Load to r0 with ID reading r0.
    clr(); ex_memread = 1; ex_regwr = 1; ex_rd = 0; id_use_rs = 1; id_rs = 0;
    mem_rd = 0; mem_regwr = 1; wb_rd = 0; wb_regwr = 1; ex_rs = 0; #1;
    chkCtl("r0_load", 1, 1, 0, 0);
    chk("r0_load.fwd_a", {30'd0, fwd_a}, 32'd0);
    tick();
    chk("r0_load.stall_cnt", stall_cnt, expStall);

    // Taken branch overrides load-use.
    clr(); ex_memread = 1; ex_regwr = 1; ex_rd = 3; id_use_rs = 1; id_rs = 3;
    ex_branch_taken = 1; #1;
    chkCtl("br_over_lu", 1, 1, 1, 1);
    tick();
    chk("br_over_lu.stall_cnt", stall_cnt, expStall);

    // Jump with no stall.
    clr(); id_jump = 1; #1;
    chkCtl("jump", 1, 1, 1, 0);

    // Forwarding priority.
    clr(); mem_rd = 5; wb_rd = 5; mem_regwr = 1; wb_regwr = 1; ex_rs = 5; ex_rt = 5; #1;
    chk("fwd_both.a", {30'd0, fwd_a}, 32'd1);
    chk("fwd_both.b", {30'd0, fwd_b}, 32'd1);
    mem_regwr = 0; #1;
    chk("fwd_wb.a", {30'd0, fwd_a}, 32'd2);
    chk("fwd_wb.b", {30'd0, fwd_b}, 32'd2);
    mem_regwr = 1; wb_rd = 6; ex_rt = 6; #1;
    chk("fwd_mix.a", {30'd0, fwd_a}, 32'd1);
    chk("fwd_mix.b", {30'd0, fwd_b}, 32'd2);
    wb_regwr = 0; #1;
    chk("fwd_none.b", {30'd0, fwd_b}, 32'd0);

    // Multiply with mflo held in ID.
    clr(); ex_md_start = 1; tick();
    ex_md_start = 0; id_md_use = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mul.busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mul.done%0d", i), {31'd0, md_done}, 32'd0);
      chk($sformatf("mul.pc_en%0d", i), {31'd0, pc_en}, 32'd0);
      tick(); expStall++;
    end
    chk("mul.end_busy", {31'd0, md_busy}, 32'd0);
    chk("mul.end_done", {31'd0, md_done}, 32'd1);
    chk("mul.end_pc_en", {31'd0, pc_en}, 32'd1);
    chk("mul.stall_cnt", stall_cnt, expStall);
    tick();
    chk("mul.done_pulse", {31'd0, md_done}, 32'd0);

    // Divide.
    clr(); ex_md_start = 1; ex_md_is_div = 1; tick();
    ex_md_start = 0; ex_md_is_div = 0; id_md_use = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("div.busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div.done%0d", i), {31'd0, md_done}, 32'd0);
      tick(); expStall++;
    end
    chk("div.end_busy", {31'd0, md_busy}, 32'd0);
    chk("div.end_done", {31'd0, md_done}, 32'd1);
    chk("div.stall_cnt", stall_cnt, expStall);
    tick();
    chk("div.done_pulse", {31'd0, md_done}, 32'd0);

    // Restart: mult abandoned after two cycles by a divide start.
    clr(); ex_md_start = 1; tick();
    ex_md_start = 0; tick(); tick();
    ex_md_start = 1; ex_md_is_div = 1; tick();
    ex_md_start = 0; ex_md_is_div = 0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("restart.busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("restart.done%0d", i), {31'd0, md_done}, 32'd0);
      tick();
    end
    chk("restart.end_done", {31'd0, md_done}, 32'd1);
    chk("restart.stall_cnt", stall_cnt, expStall);

    // Reset mid-divide at count=10 (31 - 21).
    clr(); ex_md_start = 1; ex_md_is_div = 1; tick();
    ex_md_start = 0; ex_md_is_div = 0; id_md_use = 1;
    for (int i = 0; i < 21; i++) tick();
    chk("rstmid.busy_before", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0; tick();
    chk("rstmid.busy", {31'd0, md_busy}, 32'd0);
    chk("rstmid.done", {31'd0, md_done}, 32'd0);
    chk("rstmid.stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1; tick();
    chk("rstmid.done_after", {31'd0, md_done}, 32'd0);
    chk("rstmid.busy_after", {31'd0, md_busy}, 32'd0);
    chkCtl("rstmid.ctl", 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage CPU. It drives the enable and flush controls of the PC and the IF/ID and ID/EX pipeline registers, and it selects the forwarding sources for the EX-stage ALU operands. It also tracks the multi-cycle multiply/divide unit with a busy/countdown state machine and keeps a stall-cycle performance counter. It sits beside the stage registers and reads their register-number and control outputs.

## Interface
Parameters:
- MUL_CYCLES, 5, multiply latency in cycles (range 1..255)
- DIV_CYCLES, 32, divide latency in cycles (range 1..255)

Ports:
- clk  input  1  system clock; all state updates on the falling edge, the same edge on which the pipeline registers capture
- rst_n  input  1  synchronous, active-low reset, sampled on that falling edge
- id_rs, id_rt  input  5  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  input  1  ID instruction actually reads rs / rt
- id_md_use  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- id_jump  input  1  jump resolved in ID
- ex_rd  input  5  destination register of the instruction in EX
- ex_regwr, ex_memread  input  1  EX instruction writes a register / is a load
- ex_rs, ex_rt  input  5  EX operand register numbers
- ex_branch_taken  input  1  branch resolved taken in EX
- ex_md_start  input  1  mult/div in EX starts the unit
- ex_md_is_div  input  1  qualifies ex_md_start: 1 = divide
- mem_rd, wb_rd  input  5  destinations in EX/MEM and MEM/WB
- mem_regwr, wb_regwr  input  1  write enables in EX/MEM and MEM/WB
- pc_en, ifid_en  output  1  hold the PC / IF/ID when 0
- ifid_flush, idex_flush  output  1  load a bubble (all controls zero)
- fwd_a, fwd_b  output  2  00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB write data
- md_busy  output  1  multiply/divide unit is busy
- md_done  output  1  one-cycle pulse when the result is ready
- stall_cnt  output  32  count of stalled cycles

## Operation
- Load-use hazard (lu): ex_memread & ex_regwr & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Multiply/divide hazard (mdh): md_busy & id_md_use.
- Stall = (lu | mdh) & ~ex_branch_taken. On stall: pc_en=0, ifid_en=0, idex_flush=1.
- When ex_branch_taken=1: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. A taken branch overrides any stall.
- When id_jump=1 and no stall: ifid_flush=1. During a stall, id_jump is ignored because the jump re-evaluates on the next cycle.
- Forwarding for operand A:
  - fwd_a=01 if mem_regwr & mem_rd≠0 & mem_rd==ex_rs.
  - Otherwise fwd_a=10 if wb_regwr & wb_rd≠0 & wb_rd==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b is the same with ex_rt. The EX/MEM match has priority; r0 is never forwarded.
- Multiply/divide FSM, states IDLE and BUSY, with an 8-bit count register:
  - IDLE: on ex_md_start, load count = (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY, count≠0: decrement count.
  - BUSY, count==0: go to IDLE and register md_done=1 for one cycle.
  - BUSY with ex_md_start=1: restart with the new latency. No md_done is produced for the abandoned operation.
  - md_busy = (state==BUSY).
- stall_cnt increments on every edge where stall=1. It wraps from 0xFFFFFFFF to 0.
- While rst_n=0 the combinational outputs are forced to: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00.

## Timing
- Hazard, flush and forwarding outputs are combinational from the current inputs and state, and are valid before the falling edge.
- On the falling edge with rst_n=0: state=IDLE, count=0, md_done=0, stall_cnt=0, md_busy=0. Reset while BUSY aborts the operation with no md_done.
- Multiply/divide latency: ex_md_start sampled at edge k gives md_busy=1 for exactly L cycles (edges k..k+L). md_done=1 for the one cycle after edge k+L. An mdh stall releases in that same cycle.
- A load-use stall lasts exactly one cycle. After one bubble the load sits in MEM and forwarding resolves the dependency.

## Test plan
- lw r2 in EX, ID reads rs=r2 → one cycle of pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1; next cycle fwd_a=01 for the dependent instruction in EX.
- Load to r0 with ID reading r0 → no stall and fwd_a=00 throughout.
- ex_branch_taken=1 together with a load-use condition → ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- mult start, MUL_CYCLES=5, mflo held in ID → md_busy for 5 cycles, 5 stall cycles, md_done pulses once, mflo proceeds; repeat with div → 32 stall cycles.
- mem_rd=wb_rd=r5, both writing, ex_rs=r5 → fwd_a=01; with mem_regwr=0 → fwd_a=10.
- rst_n=0 asserted mid-divide at count=10 → IDLE and md_busy=0 on the next edge, no md_done, stall_cnt=0.
